// File: rtl/secure_storage_pkg.sv
// Shared constants and types for the secure storage arbiter.
// Holds the address map, FSM state encoding and default key privileges.
package secure_storage_pkg;

    localparam logic [7:0] ADDR_DATA = 8'h00;
    localparam logic [7:0] ADDR_KEY  = 8'h01;

    // Bit i set: requester i may read/write the key address.
    localparam logic [7:0] PRIV_MASK_DEFAULT = 8'h02;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid requester at or after rr_ptr, wrapping.
// Ports: req_valid, rr_ptr in; grant (one-hot), grant_id, grant_any out.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id,
    output logic               grant_any
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_any && req_valid[idx]) begin
                grant_any  = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/secure_storage_arbiter.sv
// Shares one secure storage port between NUM_REQ requesters with
// round-robin arbitration, key privileges and a sticky key-write lock.
// Ports: req_valid/we/addr/wdata in, req_ready out (one-hot accept);
//   rsp_valid/rsp_rdata/rsp_err out; lock_key in, key_locked out;
//   st_cs/st_we/st_address/st_write_data out, st_read_data in.
// Optional: SECURE_STORAGE_AUDIT_EN adds viol_cnt and viol_id outputs.
module secure_storage_arbiter
    import secure_storage_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter logic [NUM_REQ-1:0] PRIV_MASK =
        PRIV_MASK_DEFAULT[NUM_REQ-1:0]
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    input  logic                      lock_key,
    output logic                      key_locked,
    output logic                      st_cs,
    output logic                      st_we,
    output logic [ADDR_W-1:0]         st_address,
    output logic [DATA_W-1:0]         st_write_data,
    input  logic [DATA_W-1:0]         st_read_data
`ifdef SECURE_STORAGE_AUDIT_EN
    ,
    output logic [7:0]                viol_cnt,
    output logic [$clog2(NUM_REQ)-1:0] viol_id
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    state_t             state;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     id_q;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_id;
    logic               grant_any;

    logic               in_we;
    logic [ADDR_W-1:0]  in_addr;
    logic [DATA_W-1:0]  in_wdata;
    logic               is_data;
    logic               is_key;
    logic               deny;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign in_we    = req_we[grant_id];
    assign in_addr  = req_addr[grant_id*ADDR_W +: ADDR_W];
    assign in_wdata = req_wdata[grant_id*DATA_W +: DATA_W];

    assign is_data = (in_addr == ADDR_W'(ADDR_DATA));
    assign is_key  = (in_addr == ADDR_W'(ADDR_KEY));

    // A lock pulse in the handshake cycle already blocks that key write.
    assign deny = !(is_data || is_key)
               || (is_key && !PRIV_MASK[grant_id])
               || (is_key && in_we && (key_locked || lock_key));

    // Ready is gated by reset so all outputs are 0 while reset is held.
    assign req_ready = (reset_n && state == IDLE) ? grant : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            id_q          <= '0;
            key_locked    <= 1'b0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            st_cs         <= 1'b0;
            st_we         <= 1'b0;
            st_address    <= '0;
            st_write_data <= '0;
`ifdef SECURE_STORAGE_AUDIT_EN
            viol_cnt      <= '0;
            viol_id       <= '0;
`endif
        end else begin
            if (lock_key) key_locked <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        id_q   <= grant_id;
                        rr_ptr <= (grant_id == IDW'(NUM_REQ-1))
                                ? '0 : IDW'(grant_id + 1'b1);
                        if (deny) begin
                            state     <= RESP;
                            rsp_valid <= grant;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
`ifdef SECURE_STORAGE_AUDIT_EN
                            if (viol_cnt != 8'hFF)
                                viol_cnt <= viol_cnt + 8'd1;
                            viol_id <= grant_id;
`endif
                        end else begin
                            state         <= ISSUE;
                            st_cs         <= 1'b1;
                            st_we         <= in_we;
                            st_address    <= in_addr;
                            st_write_data <= in_wdata;
                        end
                    end
                end
                ISSUE: begin
                    state         <= RESP;
                    st_cs         <= 1'b0;
                    st_we         <= 1'b0;
                    st_address    <= '0;
                    st_write_data <= '0;
                    rsp_valid     <= ONE << id_q;
                    rsp_err       <= 1'b0;
                    rsp_rdata     <= st_we ? '0 : st_read_data;
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= '0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_secure_storage_arbiter.sv
// Randomized self-checking bench for secure_storage_arbiter.
// Transaction-level model: memory contents, lock flag, next-in-turn pointer.
module tb_secure_storage_arbiter;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam logic [N-1:0] PRIV = 2'b10;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            lock_key;
    logic            key_locked;
    logic            st_cs;
    logic            st_we;
    logic [AW-1:0]   st_address;
    logic [DW-1:0]   st_write_data;
    logic [DW-1:0]   st_read_data;
`ifdef SECURE_STORAGE_AUDIT_EN
    logic [7:0]      viol_cnt;
    logic [0:0]      viol_id;
`endif

    always #5 clk = ~clk;

    secure_storage_arbiter #(
        .NUM_REQ   (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .PRIV_MASK (PRIV)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .lock_key      (lock_key),
        .key_locked    (key_locked),
        .st_cs         (st_cs),
        .st_we         (st_we),
        .st_address    (st_address),
        .st_write_data (st_write_data),
        .st_read_data  (st_read_data)
`ifdef SECURE_STORAGE_AUDIT_EN
        ,
        .viol_cnt      (viol_cnt),
        .viol_id       (viol_id)
`endif
    );

    // Storage block stand-in: combinational read, write on clock edge.
    logic [DW-1:0] st_mem [256];
    always @(posedge clk)
        if (st_cs && st_we) st_mem[st_address] <= st_write_data;
    assign st_read_data = st_mem[st_address];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [N-1:0]  pend;
    logic          p_we [N];
    logic [7:0]    p_addr [N];
    logic [31:0]   p_wd [N];
    int            ptr;
    logic          locked;
    logic [31:0]   ref_data;
    logic [31:0]   ref_key;
    int            vcnt;
    int            vid;
    logic          do_lock;
    logic [31:0]   obs_rd;
    logic          obs_err;
    logic [N-1:0]  last_grant;
    int            gcnt [N];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = pend[i];
            req_we[i]              = p_we[i];
            req_addr[i*AW +: AW]   = p_addr[i];
            req_wdata[i*DW +: DW]  = p_wd[i];
        end
    endtask

    task automatic set_req(int i, logic we, logic [7:0] a, logic [31:0] d);
        pend[i]   = 1'b1;
        p_we[i]   = we;
        p_addr[i] = a;
        p_wd[i]   = d;
    endtask

    // Runs one transaction from an IDLE cycle (time = posedge + 1).
    task automatic run_txn();
        int            g;
        logic          deny;
        logic [N-1:0]  oh;
        logic [31:0]   erd;
        logic [7:0]    a;
        drive();
        #1;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
        if (g < 0) return;
        oh = N'(1) << g;
        chk("ready", req_ready, oh);
        chk("st_cs_idle", st_cs, 0);
        last_grant = req_ready;
        a = p_addr[g];
        deny = (a != 8'h00 && a != 8'h01)
            || (a == 8'h01 && !PRIV[g])
            || (a == 8'h01 && p_we[g] && locked);
        ptr = (g + 1) % N;
        @(posedge clk);
        #1;
        pend[g] = 1'b0;
        drive();
        #1;
        chk("rdy_busy", req_ready, 0);
        if (!deny) begin
            chk("st_cs", st_cs, 1);
            chk("st_we", st_we, p_we[g]);
            chk("st_addr", st_address, a);
            chk("rsp_early", rsp_valid, 0);
            if (p_we[g]) chk("st_wd", st_write_data, p_wd[g]);
            erd = p_we[g] ? 32'h0 : (a == 8'h00 ? ref_data : ref_key);
            if (p_we[g]) begin
                if (a == 8'h00) ref_data = p_wd[g];
                else ref_key = p_wd[g];
            end
            @(posedge clk);
            #2;
        end else begin
            erd = 32'h0;
            if (vcnt < 255) vcnt++;
            vid = g;
        end
        chk("rsp_v", rsp_valid, oh);
        chk("rsp_err", rsp_err, deny);
        chk("rsp_rd", rsp_rdata, erd);
        chk("st_cs_rsp", st_cs, 0);
`ifdef SECURE_STORAGE_AUDIT_EN
        chk("viol_cnt", viol_cnt, vcnt);
        if (deny) chk("viol_id", viol_id, vid);
`endif
        obs_rd  = rsp_rdata;
        obs_err = rsp_err;
        if (do_lock) lock_key = 1'b1;
        @(posedge clk);
        #1;
        if (do_lock) begin
            lock_key = 1'b0;
            locked   = 1'b1;
            do_lock  = 1'b0;
            chk("locked", key_locked, 1);
        end
        chk("rsp_clr", rsp_valid, 0);
    endtask

    task automatic drain();
        for (int n = 0; n < 4 && pend != '0; n++) run_txn();
    endtask

    task automatic fill_random();
        int         r;
        logic [7:0] a;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 3);
                a = (r == 0) ? 8'h00 :
                    (r == 3) ? 8'($urandom_range(2, 255)) : 8'h01;
                set_req(i, 1'($urandom_range(0, 1)), a, $urandom);
            end
        end
        if (pend == '0) set_req(0, 1'b0, 8'h00, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        pend     = '0;
        for (int i = 0; i < N; i++) begin
            p_we[i] = 1'b0; p_addr[i] = 8'h00; p_wd[i] = 32'h0;
            gcnt[i] = 0;
        end
        ptr      = 0;
        locked   = 1'b0;
        ref_data = 32'h0;
        ref_key  = 32'h0;
        vcnt     = 0;
        vid      = 0;
        do_lock  = 1'b0;
        lock_key = 1'b0;
        reset_n  = 1'b0;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_v", rsp_valid, 0);
        chk("rst_rsp_rd", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_lock", key_locked, 0);
        chk("rst_cs", st_cs, 0);
        chk("rst_we", st_we, 0);
        chk("rst_addr", st_address, 0);
        chk("rst_wd", st_write_data, 0);
`ifdef SECURE_STORAGE_AUDIT_EN
        chk("rst_vcnt", viol_cnt, 0);
`endif
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Privileged key write/read, then non-privileged key read.
        set_req(0, 1'b1, 8'h00, 32'hA5A50000);
        run_txn();
        set_req(1, 1'b1, 8'h01, 32'hDEADBEEF);
        run_txn();
        set_req(1, 1'b0, 8'h01, $urandom);
        run_txn();
        chk("key_rd", obs_rd, 32'hDEADBEEF);
        set_req(0, 1'b0, 8'h01, 32'h0);
        run_txn();
        chk("np_key_err", obs_err, 1);

        // Both hold valid on the data address: grants must alternate.
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i])
                    set_req(i, 1'($urandom_range(0, 1)), 8'h00, $urandom);
            run_txn();
            if (last_grant == 2'b01) gcnt[0]++;
            else if (last_grant == 2'b10) gcnt[1]++;
        end
        drain();
        chk("fair0", gcnt[0], 10);
        chk("fair1", gcnt[1], 10);

        set_req(0, 1'b0, 8'h05, 32'h0);
        run_txn();
        chk("unmapped_err", obs_err, 1);

        for (int n = 0; n < 40; n++) begin
            fill_random();
            run_txn();
        end
        drain();

        // Lock the key, then a privileged write must be refused.
        set_req(1, 1'b1, 8'h01, 32'hDEADBEEF);
        run_txn();
        set_req(0, 1'b0, 8'h00, 32'h0);
        do_lock = 1'b1;
        run_txn();
        set_req(1, 1'b1, 8'h01, 32'h12345678);
        run_txn();
        chk("lock_wr_err", obs_err, 1);
        set_req(1, 1'b0, 8'h01, 32'h0);
        run_txn();
        chk("key_kept", obs_rd, 32'hDEADBEEF);

        for (int n = 0; n < 40; n++) begin
            fill_random();
            run_txn();
        end
        drain();
        chk("lock_sticky", key_locked, 1);

`ifdef SECURE_STORAGE_AUDIT_EN
        for (int n = 0; n < 300; n++) begin
            set_req(n % 2, 1'b0, 8'h05, 32'h0);
            run_txn();
        end
        chk("viol_sat", viol_cnt, 8'hFF);
`endif

        // Reset in the ISSUE cycle aborts the transaction.
        set_req(1, 1'b0, 8'h00, 32'h0);
        drive();
        @(posedge clk);
        #1;
        chk("abort_cs", st_cs, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_cs", st_cs, 0);
        chk("arst_addr", st_address, 0);
        chk("arst_rsp", rsp_valid, 0);
        chk("arst_lock", key_locked, 0);
        chk("arst_ready", req_ready, 0);
        pend = '0;
        drive();
        ptr    = 0;
        locked = 1'b0;
        vcnt   = 0;
        vid    = 0;
        #4;
        reset_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            chk("post_rst_rsp", rsp_valid, 0);
            chk("post_rst_cs", st_cs, 0);
        end

        // Lock cleared by reset: key writable again.
        set_req(1, 1'b1, 8'h01, 32'hCAFEF00D);
        run_txn();
        set_req(1, 1'b0, 8'h01, 32'h0);
        run_txn();
        chk("unlock_rd", obs_rd, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
